gzip_block_sequencer: RTL and testbench

GZIP-core-domain stage directly downstream of the pulse synchronizer that crosses the Xillybus "block ready" event. Its start_pl input is driven by the synchronizer's take_it_pl. On each start pulse it streams exactly block_len words from the input FWFT FIFO to the compressor over a valid/ready interface and marks the last word. On completion it issues a one-cycle done_pl, which feeds the start_pl of the return-path synchronizer to the Xillybus domain.

---
 rtl/gzip_block_sequencer.sv | 168 ++++++++++++++++
 tb/tb_gzip_block_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gzip_block_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gzip_block_sequencer
// Description : Block sequencer that sits after the block-ready pulse
//               synchronizer. On each accepted start pulse it moves exactly
//               block_len words from an FWFT FIFO to the compressor over a
//               valid/ready interface, flags the final word, and then emits
//               a one-cycle done_pl to the return-path synchronizer.
//               Optional macro GZIP_SEQ_PERF_CNT_EN adds a saturating
//               stall_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module gzip_block_sequencer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_pl,
    input  logic [LEN_W-1:0]  block_len,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              done_pl,
    output logic              busy,
    output logic              overrun_err
`ifdef GZIP_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                overrun_q, overrun_d;
    logic                load;
    logic                accept;

    // Output slot is free when empty or being accepted this cycle; issued<len
    // keeps the word counter from ever passing len, so no wrap at max length.
    assign accept = valid_q & out_ready;
    assign load   = (state_q == S_STREAM) & ~fifo_empty & (issued_q < len_q)
                  & (~valid_q | out_ready);

    // Next-state, datapath and sticky-error computation
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        issued_d  = issued_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        overrun_d = overrun_q;

        if (load) begin
            data_d   = fifo_dout;
            valid_d  = 1'b1;
            last_d   = (issued_q == (len_q - LEN_W'(1)));
            issued_d = issued_q + LEN_W'(1);
        end else if (accept) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_pl) begin
                    if (block_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_STREAM;
                        len_d    = block_len;
                        issued_d = '0;
                    end
                end
            end
            S_STREAM: begin
                if (accept && last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A start pulse that arrives while a block is in flight is dropped
        if (start_pl && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            issued_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    assign fifo_rd_en  = load;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign done_pl     = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign overrun_err = overrun_q;

`ifdef GZIP_SEQ_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Stall counter: cleared on accepted start, saturating count of STREAM
    // cycles lost to an empty FIFO or downstream back-pressure
    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start_pl) begin
            stall_d = '0;
        end else if ((state_q == S_STREAM) && (fifo_empty || (valid_q && !out_ready))
                     && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gzip_block_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gzip_block_sequencer
// Description : Directed self-checking bench for gzip_block_sequencer with a
//               transaction-level model checked every cycle and literal
//               expectations per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gzip_block_sequencer;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst, start_pl, fifo_empty, out_ready;
    logic [LW-1:0] block_len;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en, out_valid, out_last, done_pl, busy, overrun_err;
    logic [DW-1:0] out_data;
`ifdef GZIP_SEQ_PERF_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    gzip_block_sequencer #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start_pl(start_pl), .block_len(block_len),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .done_pl(done_pl), .busy(busy),
        .overrun_err(overrun_err)
`ifdef GZIP_SEQ_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;
    bit rd_cap   = 0;

    // FIFO contents and observation logs
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] beat_d[$];
    bit            beat_l[$];
    int            beat_c[$];
    int            done_c[$];
    int            busy_n;
    int            start_c;

    // Block-level model: phase 0 idle, 1 moving words, 2 completion cycle
    int            m_ph = 0;
    int            m_len = 0;
    int            m_sent = 0;
    bit            m_ov = 0, m_ol = 0, m_err = 0;
    logic [DW-1:0] m_od = '0;
    longint        m_stall = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        beat_d.delete(); beat_l.delete(); beat_c.delete(); done_c.delete();
        busy_n = 0; start_c = -1;
    endtask

    // FIFO emulation: pops on the strobe seen just before the edge
    always @(posedge clk) begin
        #2;
        if (rd_cap && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() == 0) ? 32'hDEAD_BEEF : fifo_q[0];
    end

    // Per-cycle compare against the model, logging, then model advance
    always @(negedge clk) begin
        bit exp_load, hs;
        exp_load = (m_ph == 1) && !fifo_empty && (m_sent < m_len) && (!m_ov || out_ready);
        if (chk_en) begin
            check("fifo_rd_en", fifo_rd_en, exp_load);
            check("out_valid", out_valid, m_ov);
            if (m_ov) begin
                check("out_data", out_data, m_od);
                check("out_last", out_last, m_ol);
            end
            check("done_pl", done_pl, m_ph == 2);
            check("busy", busy, m_ph != 0);
            check("overrun_err", overrun_err, m_err);
`ifdef GZIP_SEQ_PERF_CNT_EN
            check("stall_cnt", stall_cnt, m_stall);
`endif
        end
        if (!rst) begin
            if (start_pl && m_ph == 0 && start_c < 0) start_c = cyc;
            if (out_valid && out_ready) begin
                beat_d.push_back(out_data); beat_l.push_back(out_last); beat_c.push_back(cyc);
            end
            if (done_pl) done_c.push_back(cyc);
            if (busy) busy_n++;
        end
        rd_cap = fifo_rd_en;

        if (rst) begin
            m_ph = 0; m_len = 0; m_sent = 0; m_ov = 0; m_ol = 0; m_err = 0;
            m_od = '0; m_stall = 0;
        end else begin
            hs = m_ov && out_ready;
            if (m_ph == 1 && (fifo_empty || (m_ov && !out_ready)) && m_stall < 64'hFFFF_FFFF)
                m_stall++;
            if (m_ph != 0 && start_pl) m_err = 1;
            case (m_ph)
                0: if (start_pl) begin
                       m_stall = 0;
                       if (block_len == 0) m_ph = 2;
                       else begin m_ph = 1; m_len = int'(block_len); m_sent = 0; end
                   end
                1: if (hs && m_ol) m_ph = 2;
                default: m_ph = 0;
            endcase
            if (exp_load) begin
                m_od = fifo_dout; m_ov = 1; m_sent++; m_ol = (m_sent == m_len);
            end else if (hs) begin
                m_ov = 0; m_ol = 0;
            end
        end
        cyc++;
    end

    initial begin
        bit [3:0] pat;
        int gap;
        bit pushed;
        pat = 4'b1001;
        rst = 1; start_pl = 0; block_len = '0; out_ready = 0;
        fifo_empty = 1; fifo_dout = 32'hDEAD_BEEF;
        clear_logs();
        tick;
        chk_en = 1;
        tick;
        rst = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done_pl", done_pl, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun_err, 0);

        // 1: idle with preloaded FIFO, nothing may be popped
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA000_0000 + i);
        repeat (5) tick;
        check("t1_fifo_untouched", fifo_q.size(), 4);
        check("t1_rd_en", fifo_rd_en, 0);

        // 2: four-word block at full throughput
        clear_logs();
        out_ready = 1; start_pl = 1; block_len = 4;
        tick;
        start_pl = 0;
        repeat (9) tick;
        check("t2_beats", beat_d.size(), 4);
        if (beat_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_data", beat_d[i], 32'hA000_0000 + i);
                check("t2_beat_cycle", beat_c[i] - start_c, i + 2);
                check("t2_last", beat_l[i], i == 3);
            end
        end
        check("t2_done_cnt", done_c.size(), 1);
        if (done_c.size() == 1) check("t2_done_cycle", done_c[0] - start_c, 6);
        check("t2_busy_cycles", busy_n, 6);

        // 3: zero-length block
        fifo_q.delete();
        fifo_q.push_back(32'h5555_0000);
        tick;
        clear_logs();
        start_pl = 1; block_len = 0;
        tick;
        start_pl = 0;
        repeat (5) tick;
        check("t3_beats", beat_d.size(), 0);
        check("t3_done_cnt", done_c.size(), 1);
        if (done_c.size() == 1) check("t3_done_cycle", done_c[0] - start_c, 1);
        check("t3_no_pop", fifo_q.size(), 1);

        // 4: back-pressure pattern 1,0,0,1 and an empty-FIFO gap
        fifo_q.delete();
        fifo_q.push_back(32'hB000_0000);
        tick;
        clear_logs();
        gap = 0; pushed = 0;
        for (int i = 0; i < 40; i++) begin
            start_pl  = (i == 0);
            block_len = 3;
            out_ready = pat[i % 4];
            if (!pushed && i > 0 && fifo_q.size() == 0) begin
                gap++;
                if (gap == 5) begin
                    fifo_q.push_back(32'hB000_0001);
                    fifo_q.push_back(32'hB000_0002);
                    pushed = 1;
                end
            end
            tick;
        end
        start_pl = 0; out_ready = 1;
        check("t4_beats", beat_d.size(), 3);
        if (beat_d.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t4_data", beat_d[i], 32'hB000_0000 + i);
                check("t4_last", beat_l[i], i == 2);
            end
        end
        check("t4_done_cnt", done_c.size(), 1);
`ifdef GZIP_SEQ_PERF_CNT_EN
        check("t4_stall_min", stall_cnt >= 32'd5, 1);
`endif

        // 5: second start during an eight-word block
        fifo_q.delete();
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'hC000_0000 + i);
        tick;
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            start_pl  = (i == 0) || (i == 3);
            block_len = (i == 0) ? 16'd8 : 16'd5;
            out_ready = 1;
            tick;
        end
        start_pl = 0;
        check("t5_beats", beat_d.size(), 8);
        if (beat_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t5_data", beat_d[i], 32'hC000_0000 + i);
                check("t5_last", beat_l[i], i == 7);
            end
        end
        check("t5_done_cnt", done_c.size(), 1);
        check("t5_overrun_sticky", overrun_err, 1);

        // 6: reset after two of five words, then a clean two-word block
        fifo_q.delete();
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'hD000_0000 + i);
        tick;
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            start_pl  = (i == 0);
            block_len = 5;
            out_ready = 1;
            rst       = (i == 4);
            tick;
            if (i == 4) begin
                check("t6_rst_valid", out_valid, 0);
                check("t6_rst_busy", busy, 0);
                check("t6_rst_done", done_pl, 0);
                check("t6_rst_overrun", overrun_err, 0);
            end
        end
        rst = 0;
        check("t6_beats_before_rst", beat_d.size(), 2);
        check("t6_no_done", done_c.size(), 0);
        repeat (2) tick;
        fifo_q.delete();
        fifo_q.push_back(32'hE000_0000);
        fifo_q.push_back(32'hE000_0001);
        tick;
        clear_logs();
        start_pl = 1; block_len = 2;
        tick;
        start_pl = 0;
        repeat (6) tick;
        check("t6b_beats", beat_d.size(), 2);
        if (beat_d.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                check("t6b_data", beat_d[i], 32'hE000_0000 + i);
                check("t6b_last", beat_l[i], i == 1);
            end
        end
        check("t6b_done_cnt", done_c.size(), 1);

        repeat (2) tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
